// File: rtl/fade_sequencer.sv
// Multi-channel LED fade sequencer: gamma-corrected PWM with sequence, breathe,
// static and off modes, plus a per-phase fade of each channel in turn.
module fade_sequencer #(
    parameter int CHANNELS      = 3,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 18,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic [CHANNELS-1:0]           chan_mask,
    input  logic [PWM_BITS-1:0]           level_in,
    output logic [CHANNELS-1:0]           led,
    output logic [$clog2(CHANNELS+1)-1:0] phase,
    output logic                          cycle_done
);

    // state    | meaning
    // DIR_UP   | level ramps toward all-ones, one step per tick
    // DIR_DOWN | level ramps toward zero; the tick at zero advances phase

    localparam int PH_W = $clog2(CHANNELS + 1);

    localparam logic [1:0] MODE_SEQUENCE = 2'd0;
    localparam logic [1:0] MODE_BREATHE  = 2'd1;
    localparam logic [1:0] MODE_STATIC   = 2'd2;
    localparam logic [1:0] MODE_OFF      = 2'd3;

    localparam logic [PWM_BITS-1:0] LEVEL_MAX  = '1;
    localparam logic [PH_W-1:0]     PHASE_LAST = PH_W'(CHANNELS);
    localparam logic [CHANNELS-1:0] LED_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t                     dir, dir_nxt;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic [PWM_BITS-1:0]      level, level_nxt;
    logic [PRESCALE_BITS-1:0] prescaler, prescaler_nxt;
    logic [PH_W-1:0]          phase_nxt;
    logic [1:0]               mode_q;
    logic                     tick, mode_chg, cycle_done_nxt;

    logic [PWM_BITS-1:0]      bright, duty;
    logic [2*PWM_BITS-1:0]    square;
    logic [CHANNELS-1:0]      sel, active, led_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt    <= '0;
            prescaler  <= '0;
            level      <= '0;
            dir        <= DIR_UP;
            phase      <= '0;
            cycle_done <= 1'b0;
            led        <= LED_OFF;
            mode_q     <= mode;
        end else begin
            if (enable) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            prescaler  <= prescaler_nxt;
            level      <= level_nxt;
            dir        <= dir_nxt;
            phase      <= phase_nxt;
            cycle_done <= cycle_done_nxt;
            led        <= led_nxt;
            mode_q     <= mode;
        end
    end

    always_comb begin
        tick           = enable && (&prescaler);
        mode_chg       = (mode != mode_q);
        prescaler_nxt  = prescaler;
        level_nxt      = level;
        dir_nxt        = dir;
        phase_nxt      = phase;
        cycle_done_nxt = 1'b0;

        if (mode_chg) begin
            prescaler_nxt = '0;
            level_nxt     = '0;
            dir_nxt       = DIR_UP;
            phase_nxt     = '0;
        end else if (enable) begin
            prescaler_nxt = prescaler + PRESCALE_BITS'(1);
            // STATIC holds the fade so leaving it later restarts cleanly
            if (tick && (mode != MODE_STATIC)) begin
                case (dir)
                    DIR_UP: begin
                        if (level != LEVEL_MAX) begin
                            level_nxt = level + PWM_BITS'(1);
                        end else begin
                            dir_nxt = DIR_DOWN;
                        end
                    end
                    DIR_DOWN: begin
                        if (level != '0) begin
                            level_nxt = level - PWM_BITS'(1);
                        end else begin
                            dir_nxt = DIR_UP;
                            if (phase == PHASE_LAST) begin
                                phase_nxt      = '0;
                                cycle_done_nxt = 1'b1;
                            end else begin
                                phase_nxt = phase + PH_W'(1);
                            end
                        end
                    end
                    default: dir_nxt = DIR_UP;
                endcase
            end
        end
    end

    // Truncating square keeps full scale just below 100% on-time
    always_comb begin
        bright = (mode == MODE_STATIC) ? level_in : level;
        square = {{PWM_BITS{1'b0}}, bright} * {{PWM_BITS{1'b0}}, bright};
        duty   = square[2*PWM_BITS-1:PWM_BITS];

        case (mode)
            MODE_SEQUENCE: sel = (phase == PHASE_LAST) ? '1 : (CHANNELS'(1) << phase);
            MODE_BREATHE:  sel = '1;
            MODE_STATIC:   sel = '1;
            MODE_OFF:      sel = '0;
            default:       sel = '0;
        endcase

        active  = (duty > pwm_cnt) ? (sel & chan_mask) : '0;
        led_nxt = LED_OFF;
        if (enable) begin
            led_nxt = (ACTIVE_LOW != 0) ? ~active : active;
        end
    end

endmodule

// File: tb/tb_fade_sequencer.sv
// Bench for fade_sequencer: a fade-position model derived from enabled-clock counts,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_fade_sequencer;

    localparam int C   = 3;
    localparam int PB  = 4;
    localparam int NL  = 16;
    localparam int PRE = 4;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic [1:0] mode;
    logic [2:0] chan_mask;
    logic [3:0] level_in;
    logic [2:0] led;
    logic [1:0] phase;
    logic       cycle_done;

    logic       en8;
    logic [1:0] mode8;
    logic [2:0] mask8;
    logic [7:0] lvl8;
    logic [2:0] led8;
    logic [1:0] phase8;
    logic       cd8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fade_sequencer #(.CHANNELS(3), .PWM_BITS(4), .PRESCALE_BITS(2), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .chan_mask(chan_mask),
        .level_in(level_in), .led(led), .phase(phase), .cycle_done(cycle_done)
    );

    fade_sequencer #(.CHANNELS(3), .PWM_BITS(8), .PRESCALE_BITS(2), .ACTIVE_LOW(1)) dut8 (
        .clk(clk), .rst(rst), .enable(en8), .mode(mode8), .chan_mask(mask8),
        .level_in(lvl8), .led(led8), .phase(phase8), .cycle_done(cd8)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Fade position as a function of enabled, unfrozen clocks since the last clear
    function automatic int lvl_of(input int n);
        int q;
        q = (n / PRE) % (2 * NL);
        return (q < NL) ? q : (2 * NL - 1 - q);
    endfunction

    function automatic int ph_of(input int n);
        return ((n / PRE) / (2 * NL)) % (C + 1);
    endfunction

    int         m_n = 0, m_pwm = 0, m_prev = 0, e_cd = 0;
    int         m_b, m_duty, m_ph;
    bit         m_valid = 0;
    logic [2:0] e_led;

    always begin
        @(posedge clk);
        e_led = 3'b111;
        if (!rst && enable) begin
            m_b    = (mode == 2'd2) ? int'(level_in) : lvl_of(m_n);
            m_duty = (m_b * m_b) / NL;
            m_ph   = ph_of(m_n);
            for (int i = 0; i < C; i++) begin
                if (m_duty > m_pwm && chan_mask[i] &&
                    ((mode == 2'd0) ? (m_ph == C || m_ph == i) : (mode != 2'd3)))
                    e_led[i] = 1'b0;
            end
        end
        e_cd = 0;
        if (rst) begin
            m_n     = 0;
            m_pwm   = 0;
            m_valid = 1;
        end else begin
            if (enable) m_pwm = (m_pwm + 1) % NL;
            if (int'(mode) != m_prev) begin
                m_n = 0;
            end else if (enable && mode != 2'd2) begin
                m_n++;
                if (m_n % (PRE * 2 * NL * (C + 1)) == 0) e_cd = 1;
            end
        end
        m_prev = int'(mode);
        #1;
        if (m_valid) begin
            chk("model_led", int'(led), int'(e_led));
            chk("model_phase", int'(phase), ph_of(m_n));
            chk("model_cycle_done", int'(cycle_done), e_cd);
        end
    end

    int cd_cnt, cd_at, split, all_on, cnt, bad_a, bad_b, bad_c;
    int own_on[3];
    int other_on[3];
    int lows[3];

    task automatic count_lows(input int n);
        lows = '{0, 0, 0};
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (led[i] == 1'b0) lows[i]++;
        end
    endtask

    task automatic count_lows8(input int n);
        lows = '{0, 0, 0};
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (led8[i] == 1'b0) lows[i]++;
        end
    endtask

    initial begin
        rst = 1; enable = 1; mode = 2'd0; chan_mask = 3'b111; level_in = 4'd0;
        en8 = 1; mode8 = 2'd2; mask8 = 3'b111; lvl8 = 8'd16;
        repeat (3) @(negedge clk);
        chk("reset_led", int'(led), 7);
        chk("reset_phase", int'(phase), 0);
        chk("reset_cycle_done", int'(cycle_done), 0);
        rst = 0;

        // SEQUENCE walk through all phases
        cd_cnt = 0; cd_at = 0; split = 0; all_on = 0;
        own_on = '{0, 0, 0}; other_on = '{0, 0, 0};
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (cycle_done) begin cd_cnt++; cd_at = k; end
            if (k == 1)   chk("post_release_led", int'(led), 7);
            if (k == 127) chk("phase_at_127", int'(phase), 0);
            if (k == 128) chk("phase_at_128", int'(phase), 1);
            if (k == 511) chk("phase_at_511", int'(phase), 3);
            if (k == 512) chk("phase_at_512", int'(phase), 0);
            if (k <= 384) begin
                for (int i = 0; i < 3; i++) begin
                    if (led[i] == 1'b0) begin
                        if (i == (k - 1) / 128) own_on[(k - 1) / 128]++;
                        else other_on[(k - 1) / 128]++;
                    end
                end
            end else if (k <= 512) begin
                if (led != 3'b000 && led != 3'b111) split++;
                if (led == 3'b000) all_on++;
            end
        end
        for (int p = 0; p < 3; p++) begin
            chk("seq_own_channel_lit", int'(own_on[p] > 0), 1);
            chk("seq_other_channels_dark", other_on[p], 0);
        end
        chk("seq_phase3_identical", split, 0);
        chk("seq_phase3_lit", int'(all_on > 0), 1);
        chk("cycle_done_pulses", cd_cnt, 1);
        chk("cycle_done_clock", cd_at, 512);

        // Switch to BREATHE in the middle of phase 1
        repeat (100) @(negedge clk);
        mode = 2'd1;
        @(negedge clk);
        chk("mode_change_phase", int'(phase), 0);
        @(negedge clk);
        chk("mode_change_level_zero", int'(led), 7);
        split = 0; all_on = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (led != 3'b000 && led != 3'b111) split++;
            if (led == 3'b000) all_on++;
        end
        chk("breathe_identical", split, 0);
        chk("breathe_lit", int'(all_on > 0), 1);

        // BREATHE with only channel 1 unmasked
        chan_mask = 3'b010;
        @(negedge clk);
        count_lows(300);
        chk("mask_led0_dark", lows[0], 0);
        chk("mask_led2_dark", lows[2], 0);
        chk("mask_led1_lit", int'(lows[1] > 0), 1);

        // Pause mid-fade and resume
        mode = 2'd0; chan_mask = 3'b111;
        repeat (200) @(negedge clk);
        chk("pre_pause_phase", int'(phase), 1);
        enable = 0;
        bad_a = 0; bad_b = 0; bad_c = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (led != 3'b111) bad_a++;
            if (phase != 2'd1) bad_b++;
            if (cycle_done) bad_c++;
        end
        chk("pause_led_off", bad_a, 0);
        chk("pause_phase_held", bad_b, 0);
        chk("pause_no_cycle_done", bad_c, 0);
        enable = 1;
        cnt = 0;
        while (phase != 2'd2 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("resume_clocks_to_phase2", cnt, 57);

        // STATIC duty checks over one full PWM period
        mode = 2'd2; level_in = 4'd15;
        @(negedge clk);
        count_lows(16);
        chk("static15_led0", lows[0], 14);
        chk("static15_led2", lows[2], 14);
        level_in = 4'd4;
        count_lows(16);
        chk("static4_led1", lows[1], 1);
        level_in = 4'd0;
        count_lows(16);
        chk("static0_led0", lows[0], 0);
        level_in = 4'd15; chan_mask = 3'b101;
        count_lows(16);
        chk("static_masked_led1", lows[1], 0);
        chk("static_unmasked_led0", lows[0], 14);

        // OFF keeps everything dark
        mode = 2'd3; chan_mask = 3'b111;
        @(negedge clk);
        count_lows(32);
        chk("off_dark", lows[0] + lows[1] + lows[2], 0);

        // Reset mid-fade wins over a simultaneous mode change
        mode = 2'd0;
        repeat (300) @(negedge clk);
        rst = 1; mode = 2'd1;
        @(negedge clk);
        chk("midfade_reset_phase", int'(phase), 0);
        chk("midfade_reset_led", int'(led), 7);
        chk("midfade_reset_cycle_done", int'(cycle_done), 0);
        rst = 0;
        repeat (20) @(negedge clk);

        // 8-bit instance, STATIC duty over one 256-clock period
        lvl8 = 8'd16;
        count_lows8(256);
        chk("pwm8_level16_led0", lows[0], 1);
        chk("pwm8_level16_led2", lows[2], 1);
        lvl8 = 8'd128;
        count_lows8(256);
        chk("pwm8_level128_led1", lows[1], 64);
        lvl8 = 8'd255;
        count_lows8(256);
        chk("pwm8_level255_led0", lows[0], 254);
        chk("pwm8_level255_led1", lows[1], 254);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
